arbitro_ram: RTL and testbench

Two-port arbiter that shares the single-port data RAM (8-bit address, 8-bit data, RW strobe) between the microprocessor data port (port 0) and a secondary master such as a loader or DMA (port 1). It sits between the masters and the RAM inside the microcontroller top level. It serialises accesses with a req/ack handshake and round-robin fairness, and returns read data to the winning master.

---
 rtl/arbitro_ram_pkg.sv | 16 +
 rtl/arbitro_rr_sel.sv | 16 +
 rtl/arbitro_ram.sv | 107 ++++++++++
 tb/tb_arbitro_ram.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/arbitro_ram_pkg.sv
// rtl/arbitro_ram_pkg.sv - shared types and constants for the data RAM arbiter
package arbitro_ram_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    localparam logic RW_LEER     = 1'b0;
    localparam logic RW_ESCRIBIR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } estado_t;

endpackage

// File: rtl/arbitro_rr_sel.sv
// rtl/arbitro_rr_sel.sv - combinational round-robin winner select for two masters
module arbitro_rr_sel (
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic grantValid,
    output logic winner
);

    // On a tie the port that did not win last time takes the slot.
    always_comb begin
        grantValid = req0 | req1;
        winner     = (req0 && req1) ? ~lastGrant : req1;
    end

endmodule

// File: rtl/arbitro_ram.sv
// rtl/arbitro_ram.sv - two-master arbiter in front of the single-port data RAM
module arbitro_ram
    import arbitro_ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rw,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    estado_t       state;
    logic          winQ;
    logic          rwQ;
    logic          lastGrant;
    logic [DW-1:0] rdata0Q;
    logic [DW-1:0] rdata1Q;
    logic          grantValid;
    logic          winner;

    arbitro_rr_sel uSel (
        .req0       (req0),
        .req1       (req1),
        .lastGrant  (lastGrant),
        .grantValid (grantValid),
        .winner     (winner)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            winQ      <= 1'b0;
            rwQ       <= RW_LEER;
            lastGrant <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= RW_LEER;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            rdata0Q   <= '0;
            rdata1Q   <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        winQ      <= winner;
                        rwQ       <= winner ? rw1 : rw0;
                        mem_addr  <= winner ? addr1 : addr0;
                        mem_wdata <= winner ? wdata1 : wdata0;
                        mem_rw    <= winner ? rw1 : rw0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        mem_rw <= RW_LEER;
                    end
                end
                ISSUE: begin
                    // Drop the strobe before DONE so a write lands exactly once.
                    mem_rw <= RW_LEER;
                    ack0   <= ~winQ;
                    ack1   <= winQ;
                    state  <= DONE;
                end
                DONE: begin
                    if (rwQ == RW_LEER) begin
                        if (winQ) rdata1Q <= mem_rdata;
                        else      rdata0Q <= mem_rdata;
                    end
                    lastGrant <= winQ;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_rw <= RW_LEER;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // The RAM answers only in DONE, so read data is forwarded while ack is high
    // and the captured copy is presented from then on.
    assign rdata0 = (ack0 && rwQ == RW_LEER) ? mem_rdata : rdata0Q;
    assign rdata1 = (ack1 && rwQ == RW_LEER) ? mem_rdata : rdata1Q;

endmodule

// File: tb/tb_arbitro_ram.sv
// tb/tb_arbitro_ram.sv - self-checking bench for arbitro_ram
module tb_arbitro_ram;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       req0, rw0, req1, rw1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, mem_rw, busy;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [7:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    arbitro_ram dut (
        .Clk(Clk), .Rst(Rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Single-port RAM with synchronous read.
    logic [7:0] ram [256];
    always @(posedge Clk) begin
        if (mem_rw) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: each accepted request occupies three cycles
    // (decision, RAM access, completion), ties alternate between ports.
    int         mPhase = 0;
    logic       mWin = 1'b0, mWr = 1'b0, mLast = 1'b1;
    logic [7:0] mAddr = 8'h00, mData = 8'h00;
    logic [7:0] mMem [256];
    logic [7:0] mHeld [2];
    bit         modelOn = 1'b0;

    function automatic logic pickWin(input logic r0, input logic r1, input logic lastG);
        if (r0 && r1) return !lastG;
        return r1;
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            mPhase   <= 0;
            mLast    <= 1'b1;
            mHeld[0] <= 8'h00;
            mHeld[1] <= 8'h00;
        end else if (mPhase == 0) begin
            if (req0 || req1) begin
                mWin   <= pickWin(req0, req1, mLast);
                mWr    <= pickWin(req0, req1, mLast) ? rw1 : rw0;
                mAddr  <= pickWin(req0, req1, mLast) ? addr1 : addr0;
                mData  <= pickWin(req0, req1, mLast) ? wdata1 : wdata0;
                mPhase <= 1;
            end
        end else if (mPhase == 1) begin
            if (mWr) mMem[mAddr] <= mData;
            mPhase <= 2;
        end else begin
            if (!mWr) mHeld[mWin] <= mMem[mAddr];
            mLast  <= mWin;
            mPhase <= 0;
        end
        modelOn <= 1'b1;
    end

    always @(negedge Clk) begin
        if (modelOn) begin
            chk("busy", busy, mPhase != 0);
            chk("mem_rw", mem_rw, mPhase == 1 && mWr);
            chk("ack0", ack0, mPhase == 2 && !mWin);
            chk("ack1", ack1, mPhase == 2 && mWin);
            chk("ack_excl", ack0 & ack1, 0);
            chk("rdata0", rdata0, (mPhase == 2 && !mWin && !mWr) ? mMem[mAddr] : mHeld[0]);
            chk("rdata1", rdata1, (mPhase == 2 && mWin && !mWr) ? mMem[mAddr] : mHeld[1]);
            if (mPhase == 1) begin
                chk("mem_addr", mem_addr, mAddr);
                if (mWr) chk("mem_wdata", mem_wdata, mData);
            end
        end
    end

    task automatic access(input int port, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int rwHigh);
        bit got = 0;
        @(negedge Clk);
        if (port == 0) begin req0 = 1; rw0 = wr; addr0 = a; wdata0 = d; end
        else           begin req1 = 1; rw1 = wr; addr1 = a; wdata1 = d; end
        lat = 0; rwHigh = 0; rd = 8'h00;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge Clk);
            lat++;
            if (mem_rw) rwHigh++;
            if ((port == 0) ? ack0 : ack1) begin
                got = 1;
                rd = (port == 0) ? rdata0 : rdata1;
            end
        end
        req0 = 0; req1 = 0;
        chk("ack_seen", got, 1);
    endtask

    logic [7:0] rd;
    int lat, rwHigh;
    int ackPort[$];
    int ackCyc[$];

    initial begin
        Rst = 1; req0 = 1; req1 = 1; rw0 = 1; rw1 = 1;
        addr0 = 8'h20; wdata0 = 8'h11; addr1 = 8'h31; wdata1 = 8'h22;
        repeat (2) @(negedge Clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_rdata", {rdata0, rdata1}, 16'h0000);

        // Both ports contend straight out of reset.
        Rst = 0;
        for (int i = 0; i < 20 && ackPort.size() < 4; i++) begin
            @(negedge Clk);
            if (ack0 || ack1) begin
                ackPort.push_back(ack1 ? 1 : 0);
                ackCyc.push_back(cyc);
            end
            if (ackPort.size() == 4) begin req0 = 0; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        chk("cont_count", ackPort.size(), 4);
        if (ackPort.size() == 4) begin
            chk("first_grant", ackPort[0], 0);
            chk("cont_order", {ackPort[1][0], ackPort[2][0], ackPort[3][0]}, 3'b101);
            for (int i = 1; i < 4; i++) chk("cont_spacing", ackCyc[i] - ackCyc[i-1], 3);
        end

        access(0, 1, 8'h10, 8'h5A, rd, lat, rwHigh);
        chk("wr_latency", lat, 2);
        chk("wr_rw_cycles", rwHigh, 1);
        access(0, 0, 8'h10, 8'h00, rd, lat, rwHigh);
        chk("rd_latency", lat, 2);
        chk("rd_rw_cycles", rwHigh, 0);
        chk("rd_data0", rd, 8'h5A);

        access(1, 1, 8'hFF, 8'hC3, rd, lat, rwHigh);
        access(0, 0, 8'hFF, 8'h00, rd, lat, rwHigh);
        chk("xport_rdata0", rd, 8'hC3);
        chk("xport_rdata1", rdata1, 8'h00);

        @(negedge Clk);
        req1 = 1; rw1 = 0; addr1 = 8'h10;
        @(negedge Clk);
        chk("mid_busy", busy, 1);
        Rst = 1;
        @(negedge Clk);
        chk("mid_ack1", ack1, 0);
        chk("mid_busy_after", busy, 0);
        chk("mid_mem_rw", mem_rw, 0);
        Rst = 0; req1 = 0;
        @(negedge Clk);
        chk("mid_no_late_ack", ack1, 0);
        access(1, 0, 8'h10, 8'h00, rd, lat, rwHigh);
        chk("rereq_rdata1", rd, 8'h5A);
        chk("rereq_latency", lat, 2);

        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            chk("idle_quiet", {busy, mem_rw, ack0, ack1}, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
